// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the requesters, the round-robin arbiter and the FIFO write side.
// The master modport is the arbiter; the slave modport is the requester/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 10
);
  logic [NUM_REQ-1:0]            req_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i;
  logic [NUM_REQ-1:0]            ack_o;
  logic [NUM_REQ-1:0]            grant_o;
  logic                          fifo_full_i;
  logic                          fifo_wr_en_o;
  logic [DATA_WIDTH-1:0]         fifo_wdata_o;
  logic                          stall_o;

  modport master (
    input  req_i, wdata_i, fifo_full_i,
    output ack_o, grant_o, fifo_wr_en_o, fifo_wdata_o, stall_o
  );

  modport slave (
    output req_i, wdata_i, fifo_full_i,
    input  ack_o, grant_o, fifo_wr_en_o, fifo_wdata_o, stall_o
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of a FIFO write port, bursts of up to MAX_BURST words per grant; grant 1 cycle after request.
// Writes are zero-latency against the grant; a full FIFO holds the grant and stalls the owner with no timeout.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 10,
  parameter int MAX_BURST  = 4,
  parameter int IDX_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  fifo_wr_arbiter_if.master bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0]           LAST_BEAT = 8'(MAX_BURST - 1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_REQ - 1);
  localparam logic [IDX_WIDTH:0]   NUM_REQ_W = (IDX_WIDTH + 1)'(NUM_REQ);

  state_t                state_q, state_d;
  logic [IDX_WIDTH-1:0]  owner_q, owner_d;
  logic [IDX_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]            burst_cnt_q, burst_cnt_d;

  logic                  any_req;
  logic                  owner_req;
  logic                  granted;
  logic                  xfer;
  logic                  release_grant;
  logic [IDX_WIDTH-1:0]  next_ptr;
  logic [IDX_WIDTH-1:0]  idle_pick;
  logic [IDX_WIDTH-1:0]  release_pick;
  logic [DATA_WIDTH-1:0] slice [NUM_REQ];
  logic [NUM_REQ-1:0]    ack_d;
  logic [NUM_REQ-1:0]    grant_d;

  // First requester at or after 'start', wrapping modulo NUM_REQ.
  function automatic logic [IDX_WIDTH-1:0] rr_pick(
    input logic [NUM_REQ-1:0]   req,
    input logic [IDX_WIDTH-1:0] start
  );
    logic [IDX_WIDTH-1:0] pick;
    logic [IDX_WIDTH:0]   sum;
    logic [IDX_WIDTH-1:0] cand;
    logic                 found;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, start} + (IDX_WIDTH + 1)'(i);
      if (sum >= NUM_REQ_W) begin
        sum = sum - NUM_REQ_W;
      end
      cand = sum[IDX_WIDTH-1:0];
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      slice[k] = bus.wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign any_req      = |bus.req_i;
  assign owner_req    = bus.req_i[owner_q];
  assign granted      = (state_q == GRANT);
  assign next_ptr     = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
  assign idle_pick    = rr_pick(bus.req_i, rr_ptr_q);
  assign release_pick = rr_pick(bus.req_i, next_ptr);

  // Reset gates every write-side output so a reset mid-burst never lands a word.
  assign xfer          = rst_i && granted && owner_req && !bus.fifo_full_i;
  assign release_grant = !owner_req || (xfer && (burst_cnt_q == LAST_BEAT));

  always_comb begin
    ack_d   = '0;
    grant_d = '0;
    if (xfer) begin
      ack_d[owner_q] = 1'b1;
    end
    if (granted) begin
      grant_d[owner_q] = 1'b1;
    end
  end

  assign bus.ack_o        = ack_d;
  assign bus.grant_o      = grant_d;
  assign bus.fifo_wr_en_o = xfer;
  assign bus.stall_o      = rst_i && granted && owner_req && bus.fifo_full_i;
  assign bus.fifo_wdata_o = (rst_i && granted) ? slice[owner_q] : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d     = GRANT;
          owner_d     = idle_pick;
          burst_cnt_d = '0;
        end
      end
      GRANT: begin
        if (release_grant) begin
          rr_ptr_d = next_ptr;
          // Hand straight over to the next requester; the old owner is searched last.
          if (any_req) begin
            owner_d     = release_pick;
            burst_cnt_d = '0;
          end else begin
            state_d     = IDLE;
            burst_cnt_d = '0;
          end
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a cycle-level reference model.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 10;

  logic              clk = 1'b0;
  logic              rst_a = 1'b0;
  logic              rst_b = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR*DW-1:0]  wd = '0;
  logic              full = 1'b0;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus4 ();
  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus1 ();

  assign bus4.req_i       = req;
  assign bus4.wdata_i     = wd;
  assign bus4.fifo_full_i = full;
  assign bus1.req_i       = req;
  assign bus1.wdata_i     = wd;
  assign bus1.fifo_full_i = full;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4)) dut4 (
    .clk_i (clk),
    .rst_i (rst_a),
    .bus   (bus4)
  );

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(1)) dut1 (
    .clk_i (clk),
    .rst_i (rst_b),
    .bus   (bus1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pend [NR];
  bit rand_data = 1'b1;
  bit sel1 = 1'b0;

  logic [NR-1:0] obs_ack, obs_grant;
  logic          obs_wr, obs_stall;
  logic [DW-1:0] obs_wdata;
  logic [19:0]   obs_vec, exp_vec;

  // Reference model: who owns the port, how many words it has written this grant, where the search starts.
  int  m_max = 4;
  bit  m_busy = 1'b0;
  int  m_owner = 0;
  int  m_ptr = 0;
  int  m_words = 0;
  logic [NR-1:0] e_ack, e_grant;
  logic          e_wr, e_stall;
  logic [DW-1:0] e_wdata;

  int wq_dat [$];
  int wq_src [$];
  int wq_cyc [$];

  function automatic int first_from(int start, logic [NR-1:0] r);
    for (int i = 0; i < NR; i++) begin
      if (r[(start + i) % NR]) return (start + i) % NR;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic active_rst();
    return sel1 ? rst_b : rst_a;
  endfunction

  function automatic void model_eval();
    e_grant = m_busy ? NR'(1 << m_owner) : '0;
    e_ack   = '0;
    e_wr    = 1'b0;
    e_stall = 1'b0;
    e_wdata = '0;
    if (active_rst() && m_busy) begin
      e_wdata = wd[m_owner*DW +: DW];
      if (req[m_owner]) begin
        if (full) begin
          e_stall = 1'b1;
        end else begin
          e_wr  = 1'b1;
          e_ack = NR'(1 << m_owner);
        end
      end
    end
    exp_vec = {e_ack, e_grant, e_wr, e_wdata, e_stall};
  endfunction

  function automatic void model_edge();
    if (!active_rst()) begin
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_words = 0;
    end else if (!m_busy) begin
      if (req != '0) begin
        m_busy = 1'b1; m_owner = first_from(m_ptr, req); m_words = 0;
      end
    end else if (!req[m_owner] || (!full && (m_words + 1 == m_max))) begin
      m_ptr = (m_owner + 1) % NR;
      if (req != '0) begin
        m_owner = first_from(m_ptr, req); m_words = 0;
      end else begin
        m_busy = 1'b0;
      end
    end else if (!full) begin
      m_words = m_words + 1;
    end
  endfunction

  function automatic void apply_req();
    for (int k = 0; k < NR; k++) req[k] = (pend[k] > 0);
  endfunction

  task automatic sample();
    @(negedge clk);
    if (sel1) begin
      obs_ack = bus1.ack_o; obs_grant = bus1.grant_o; obs_wr = bus1.fifo_wr_en_o;
      obs_wdata = bus1.fifo_wdata_o; obs_stall = bus1.stall_o;
    end else begin
      obs_ack = bus4.ack_o; obs_grant = bus4.grant_o; obs_wr = bus4.fifo_wr_en_o;
      obs_wdata = bus4.fifo_wdata_o; obs_stall = bus4.stall_o;
    end
    obs_vec = {obs_ack, obs_grant, obs_wr, obs_wdata, obs_stall};
    model_eval();
    if (obs_wr === 1'b1) begin
      wq_dat.push_back(int'(obs_wdata));
      wq_src.push_back(onehot_idx(obs_ack));
      wq_cyc.push_back(cyc);
    end
  endtask

  // Advances one clock; requesters step past acked words and drop req when out of data.
  task automatic tick();
    logic [NR-1:0] acked;
    acked = obs_ack;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    for (int k = 0; k < NR; k++) begin
      if (acked[k] === 1'b1 && pend[k] > 0) begin
        pend[k]--;
        if (rand_data) wd[k*DW +: DW] = DW'($urandom);
      end
    end
    apply_req();
  endtask

  task automatic do_reset();
    for (int k = 0; k < NR; k++) pend[k] = 0;
    apply_req();
    full = 1'b0;
    if (sel1) rst_b = 1'b0; else rst_a = 1'b0;
    sample();
    tick();
    if (sel1) rst_b = 1'b1; else rst_a = 1'b1;
    wq_dat.delete(); wq_src.delete(); wq_cyc.delete();
  endtask

  task automatic test_reset();
    for (int k = 0; k < NR; k++) pend[k] = $urandom_range(1, 3);
    apply_req();
    for (int l = 0; l < 3; l++) begin
      sample();
      checks++;
      if (obs_vec !== 20'h0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got=%h want=%h", cyc, obs_vec, 20'h0);
      end
      tick();
    end
    for (int k = 0; k < NR; k++) pend[k] = 0;
    apply_req();
    rst_a = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    rand_data = 1'b0;
    wd[2*DW +: DW] = 10'h155;
    pend[2] = 3;
    apply_req();
    for (int l = 0; l < 7; l++) begin
      sample();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL single_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
      if (l == 1) begin
        checks++;
        if (obs_grant !== 4'b0100) begin
          errors++;
          $display("FAIL single_grant_latency got=%b want=0100", obs_grant);
        end
      end
      tick();
    end
    checks++;
    if (wq_dat.size() != 3 || obs_grant !== 4'b0000) begin
      errors++;
      $display("FAIL single_count words=%0d want=3 final_grant=%b want=0000", wq_dat.size(), obs_grant);
    end
    foreach (wq_dat[i]) begin
      checks++;
      if (wq_dat[i] != 'h155) begin
        errors++;
        $display("FAIL single_data idx=%0d got=%h want=155", i, wq_dat[i]);
      end
    end
    rand_data = 1'b1;
  endtask

  task automatic test_all_four();
    int c0;
    do_reset();
    for (int k = 0; k < NR; k++) pend[k] = 50;
    apply_req();
    c0 = cyc;
    for (int l = 0; l < 20; l++) begin
      sample();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL all4_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
      tick();
    end
    checks++;
    if (wq_src.size() < 17 || wq_cyc[0] != c0 + 1) begin
      errors++;
      $display("FAIL all4_start words=%0d want>=17", wq_src.size());
    end else begin
      for (int i = 0; i < 17; i++) begin
        checks++;
        if (wq_src[i] != (i / 4) % NR || wq_cyc[i] != c0 + 1 + i) begin
          errors++;
          $display("FAIL all4_order idx=%0d src=%0d want=%0d cyc=%0d want=%0d",
                   i, wq_src[i], (i / 4) % NR, wq_cyc[i], c0 + 1 + i);
        end
      end
    end
  endtask

  task automatic test_stall();
    int stalls;
    stalls = 0;
    do_reset();
    pend[1] = 4;
    apply_req();
    for (int l = 0; l < 12; l++) begin
      full = (l >= 3 && l <= 7);
      sample();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL stall_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
      if (l >= 3 && l <= 7) begin
        checks++;
        if (obs_stall !== 1'b1 || obs_ack !== 4'b0000 || obs_grant !== 4'b0010) begin
          errors++;
          $display("FAIL stall_hold l=%0d stall=%b ack=%b grant=%b want 1/0000/0010", l, obs_stall, obs_ack, obs_grant);
        end
      end
      if (obs_stall === 1'b1) stalls++;
      tick();
    end
    full = 1'b0;
    checks++;
    if (stalls != 5 || wq_src.size() != 4 || obs_grant !== 4'b0000) begin
      errors++;
      $display("FAIL stall_summary stalls=%0d want=5 words=%0d want=4 grant=%b want=0000", stalls, wq_src.size(), obs_grant);
    end
  endtask

  task automatic test_drop();
    do_reset();
    pend[2] = 1;
    apply_req();
    for (int l = 0; l < 13; l++) begin
      if (l == 1) begin
        pend[0] = 6; pend[3] = 6;
        apply_req();
      end
      sample();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL drop_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
      tick();
    end
    checks++;
    if (wq_src.size() < 6 || wq_src[0] != 2 || wq_src[1] != 3 || wq_src[4] != 3 || wq_src[5] != 0
        || wq_cyc[1] != wq_cyc[0] + 2) begin
      errors++;
      $display("FAIL drop_order words=%0d first srcs=%p want 2,3,3,3,3,0 with one gap", wq_src.size(), wq_src);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pend[1] = 4;
    apply_req();
    for (int l = 0; l < 11; l++) begin
      if (l == 5) begin
        pend[3] = 10; pend[0] = 10;
        apply_req();
      end
      if (l == 7) rst_a = 1'b0;
      if (l == 8) rst_a = 1'b1;
      sample();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL rstmid_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
      if (l == 7) begin
        checks++;
        if (obs_wr !== 1'b0 || obs_ack !== 4'b0000 || obs_grant !== 4'b1000) begin
          errors++;
          $display("FAIL rstmid_write wr=%b ack=%b grant=%b want 0/0000/1000", obs_wr, obs_ack, obs_grant);
        end
      end
      if (l == 8 || l == 9) begin
        checks++;
        if (obs_grant !== ((l == 8) ? 4'b0000 : 4'b0001)) begin
          errors++;
          $display("FAIL rstmid_grant l=%0d got=%b want=%b", l, obs_grant, (l == 8) ? 4'b0000 : 4'b0001);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int l = 0; l < 400; l++) begin
      for (int k = 0; k < NR; k++) begin
        if (pend[k] == 0 && $urandom_range(0, 3) == 0) begin
          pend[k] = $urandom_range(1, 9);
          wd[k*DW +: DW] = DW'($urandom);
        end
      end
      apply_req();
      full = ($urandom_range(0, 9) < 3);
      sample();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL random_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
      tick();
    end
    full = 1'b0;
  endtask

  task automatic test_back_to_back();
    sel1 = 1'b1;
    m_max = 1;
    do_reset();
    pend[3] = 40;
    apply_req();
    for (int l = 0; l < 12; l++) begin
      sample();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL b2b_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
      end
      if (l >= 1) begin
        checks++;
        if (obs_ack !== 4'b1000 || obs_wr !== 1'b1 || obs_grant !== 4'b1000) begin
          errors++;
          $display("FAIL b2b_steady l=%0d ack=%b wr=%b grant=%b want 1000/1/1000", l, obs_ack, obs_wr, obs_grant);
        end
      end
      tick();
    end
    checks++;
    if (wq_src.size() != 11 || wq_cyc[10] != wq_cyc[0] + 10) begin
      errors++;
      $display("FAIL b2b_count words=%0d want=11", wq_src.size());
    end
  endtask

  initial begin
    for (int k = 0; k < NR; k++) pend[k] = 0;
    wd = {NR{10'h0}};
    test_reset();
    test_single();
    test_all_four();
    test_stall();
    test_drop();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
